v2f_frame_rx: RTL and testbench
===============================

Name: v2f_frame_rx

Overview:
Receiving end of the 32-bit circuit-network word link between combinator-mapped logic and conventional RTL. The link carries one 32-bit signal plus a strobe and has no backpressure. The block parses framed word streams (header, payload, checksum) and buffers payload words in a FIFO. A frame's payload is released downstream on a valid/ready interface only after its checksum verifies. Bad frames are dropped atomically and flagged.

Parameters:
FIFO_DEPTH  16  payload buffer entries; power of two, >= MAX_LEN
MAX_LEN  8  maximum payload words per frame, 1..255
MAGIC  16'h5646  required value of header bits [31:16]

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
rx_valid  input  1  rx_data holds a link word this cycle
rx_data  input  32  link word
out_valid  output  1  committed payload word available
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  32  payload word
out_last  output  1  out_data is the final word of its frame
err_magic  output  1  one-cycle pulse: header magic mismatch
err_len  output  1  one-cycle pulse: header length 0 or > MAX_LEN
err_crc  output  1  one-cycle pulse: checksum mismatch
err_ovf  output  1  one-cycle pulse: frame dropped because the FIFO filled
frames_ok  output  16  count of committed frames, wraps at 2^16

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: all outputs 0; FIFO empty; FSM in IDLE. Reset asserted mid-frame discards everything, including committed but unread words.
- Word acceptance: a word is consumed only on a cycle where rx_valid=1.
- FSM IDLE, on a word:
  - bits[31:16] != MAGIC -> stay IDLE, pulse err_magic.
  - len = bits[7:0]; len==0 or len>MAX_LEN -> stay IDLE, pulse err_len.
  - otherwise -> latch len, set remaining=len, sum=word, move to PAYLOAD.
  - Header bits[15:8] are ignored but are included in the checksum.
- FSM PAYLOAD, on a word:
  - sum += word (mod 2^32).
  - If not dropping: write {last=(remaining==1), word} at wr_ptr and advance wr_ptr.
  - remaining -= 1; when remaining reaches 0, move to CHECK.
- FSM CHECK, on a word:
  - If not dropping and word==sum: commit_ptr <= wr_ptr, frames_ok += 1.
  - If not dropping and word != sum: wr_ptr <= commit_ptr (rollback), pulse err_crc.
  - Always return to IDLE and clear the drop flag.
- Overflow: a payload write attempted while occupancy (wr_ptr - rd_ptr) == FIFO_DEPTH:
  - set the drop flag, roll wr_ptr back to commit_ptr, pulse err_ovf once;
  - remaining words of the frame, including its checksum, are consumed and ignored;
  - the FSM still counts remaining and returns to IDLE after the checksum word;
  - err_crc is never pulsed for a dropped frame.
- Full check uses registered pointers. A pop in the same cycle does not create room for that cycle's push.
- Pointers: log2(FIFO_DEPTH)+1 bits with natural wrap-around. Empty: rd_ptr==commit_ptr. Full: wr_ptr - rd_ptr == FIFO_DEPTH.
- Output side:
  - out_valid = (rd_ptr != commit_ptr); out_data/out_last are driven from the entry at rd_ptr.
  - Pop on out_valid && out_ready.
  - Uncommitted words are never visible.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Latency:
  - checksum word accepted at cycle T -> out_valid=1 at T+1 (the FIFO was empty beforehand);
  - error pulses are asserted at T+1 for an offending word at T;
  - the commit and a pop may occur in the same cycle.
- Back-to-back frames: a header may arrive on the cycle immediately after a checksum word; no idle gap is required.
- rx_valid=0 cycles inside a frame are legal gaps; the FSM holds state and there is no timeout.

Test Plan:
- Good frame: words 0x56460002, 0x00000011, 0x00000022, 0x56460035 with out_ready=1.
  - Required: out_valid rises the cycle after the checksum word.
  - Required: outputs 0x11 (last=0), then 0x22 (last=1); frames_ok=1; no error pulses.
- Bad checksum: same frame with checksum 0x56460036.
  - Required: err_crc pulses once; out_valid never rises; frames_ok=0.
  - Required: a following good frame is delivered intact.
- Header errors:
  - 0x12340002 -> err_magic pulses and the FSM stays IDLE.
  - 0x56460000 -> err_len pulses.
  - 0x56460009 with MAX_LEN=8 -> err_len pulses; following words are parsed as headers.
- Overflow, FIFO_DEPTH=16, out_ready=0:
  - Send two good 8-word frames: both commit, occupancy is 16, frames_ok=2.
  - Send a third 2-word frame: err_ovf pulses once and no err_crc.
  - Required: with out_ready=1 exactly the 16 words of frames 1 and 2 drain, with out_last on words 8 and 16.
- Stall and gaps:
  - Good frame with rx_valid=0 gaps between every word and out_ready toggling 1/0.
  - Required: identical data and order; out_data stable while stalled.
- Reset mid-frame: assert rst after the header and first payload word of a frame, while frame 1 sits committed and unread.
  - Required: all outputs 0 immediately; FIFO empty; frames_ok=0.
  - Required: a new good frame after reset is received correctly.

Source files
------------

// File: rtl/v2f_frame_rx.sv
// v2f_frame_rx: receive side of the 32-bit word link.
// Parses framed word streams (header, payload, checksum) and buffers the
// payload in a FIFO. A frame becomes visible downstream only after its
// checksum matches. Bad or overflowing frames are rolled back as a unit.
module v2f_frame_rx #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          MAX_LEN    = 8,
    parameter logic [15:0] MAGIC      = 16'h5646
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        err_magic,
    output logic        err_len,
    output logic        err_crc,
    output logic        err_ovf,
    output logic [15:0] frames_ok
);

    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam int              PW      = AW + 1;
    localparam logic [PW-1:0]   DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [7:0]      LEN_MAX = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    // Control state
    state_t          r_state;
    logic [7:0]      r_rem;
    logic            r_drop;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_commit_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_err_magic;
    logic            r_err_len;
    logic            r_err_crc;
    logic            r_err_ovf;
    logic [15:0]     r_frames_ok;

    // Datapath state (never reset: contents only matter once written)
    logic [31:0]     r_sum;
    logic [32:0]     r_mem [FIFO_DEPTH];

    // Next-state values
    state_t          w_state_n;
    logic [7:0]      w_rem_n;
    logic            w_drop_n;
    logic [PW-1:0]   w_wr_ptr_n;
    logic [PW-1:0]   w_commit_ptr_n;
    logic [PW-1:0]   w_rd_ptr_n;
    logic            w_err_magic_n;
    logic            w_err_len_n;
    logic            w_err_crc_n;
    logic            w_err_ovf_n;
    logic [15:0]     w_frames_ok_n;
    logic [31:0]     w_sum_n;

    logic            w_wr_en;
    logic            w_wr_last;
    logic            w_full;
    logic            w_out_valid;
    logic            w_pop;
    logic [31:0]     w_sum_add;
    logic [32:0]     w_head;

    // Fullness counts uncommitted words too, and uses registered pointers so a
    // same-cycle pop never makes room for that cycle's write.
    assign w_full      = ((r_wr_ptr - r_rd_ptr) == DEPTH_P);
    assign w_out_valid = (r_rd_ptr != r_commit_ptr);
    assign w_pop       = w_out_valid && out_ready;
    assign w_sum_add   = r_sum + rx_data;
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

    // Outputs are forced to zero while nothing is committed so reset and
    // empty states present clean zeros instead of stale buffer contents.
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? w_head[31:0] : 32'd0;
    assign out_last  = w_out_valid ? w_head[32]   : 1'b0;
    assign err_magic = r_err_magic;
    assign err_len   = r_err_len;
    assign err_crc   = r_err_crc;
    assign err_ovf   = r_err_ovf;
    assign frames_ok = r_frames_ok;

    // Frame parser: next-state, pointer and error-pulse decisions
    always_comb begin
        w_state_n      = r_state;
        w_rem_n        = r_rem;
        w_drop_n       = r_drop;
        w_wr_ptr_n     = r_wr_ptr;
        w_commit_ptr_n = r_commit_ptr;
        w_rd_ptr_n     = r_rd_ptr;
        w_err_magic_n  = 1'b0;
        w_err_len_n    = 1'b0;
        w_err_crc_n    = 1'b0;
        w_err_ovf_n    = 1'b0;
        w_frames_ok_n  = r_frames_ok;
        w_sum_n        = r_sum;
        w_wr_en        = 1'b0;
        w_wr_last      = 1'b0;

        if (w_pop) begin
            w_rd_ptr_n = r_rd_ptr + 1'b1;
        end

        if (rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_data[31:16] != MAGIC) begin
                        w_err_magic_n = 1'b1;
                    end else if ((rx_data[7:0] == 8'd0) || (rx_data[7:0] > LEN_MAX)) begin
                        w_err_len_n = 1'b1;
                    end else begin
                        w_rem_n   = rx_data[7:0];
                        w_sum_n   = rx_data;
                        w_drop_n  = 1'b0;
                        w_state_n = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_sum_n = w_sum_add;
                    if (!r_drop) begin
                        if (w_full) begin
                            // Discard the partial frame; the rest of it,
                            // checksum included, is swallowed silently.
                            w_drop_n    = 1'b1;
                            w_wr_ptr_n  = r_commit_ptr;
                            w_err_ovf_n = 1'b1;
                        end else begin
                            w_wr_en    = 1'b1;
                            w_wr_last  = (r_rem == 8'd1);
                            w_wr_ptr_n = r_wr_ptr + 1'b1;
                        end
                    end
                    w_rem_n = r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        w_state_n = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!r_drop) begin
                        if (rx_data == r_sum) begin
                            w_commit_ptr_n = r_wr_ptr;
                            w_frames_ok_n  = r_frames_ok + 16'd1;
                        end else begin
                            w_wr_ptr_n  = r_commit_ptr;
                            w_err_crc_n = 1'b1;
                        end
                    end
                    w_drop_n  = 1'b0;
                    w_state_n = ST_IDLE;
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rem        <= 8'd0;
            r_drop       <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_err_magic  <= 1'b0;
            r_err_len    <= 1'b0;
            r_err_crc    <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_frames_ok  <= 16'd0;
        end else begin
            r_state      <= w_state_n;
            r_rem        <= w_rem_n;
            r_drop       <= w_drop_n;
            r_wr_ptr     <= w_wr_ptr_n;
            r_commit_ptr <= w_commit_ptr_n;
            r_rd_ptr     <= w_rd_ptr_n;
            r_err_magic  <= w_err_magic_n;
            r_err_len    <= w_err_len_n;
            r_err_crc    <= w_err_crc_n;
            r_err_ovf    <= w_err_ovf_n;
            r_frames_ok  <= w_frames_ok_n;
        end
    end

    // Payload buffer write and running checksum
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_wr_last, rx_data};
        end
        r_sum <= w_sum_n;
    end

endmodule

// File: tb/tb_v2f_frame_rx.sv
// Bench for v2f_frame_rx: directed frames, expected payload pushed into a
// scoreboard queue and popped by a concurrent output monitor.
module tb_v2f_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        err_magic;
    logic        err_len;
    logic        err_crc;
    logic        err_ovf;
    logic [15:0] frames_ok;

    v2f_frame_rx #(.FIFO_DEPTH(16), .MAX_LEN(8), .MAGIC(16'h5646)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_magic (err_magic),
        .err_len   (err_len),
        .err_crc   (err_crc),
        .err_ovf   (err_ovf),
        .frames_ok (frames_ok)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] sb [$];
    int          n_magic = 0, n_len = 0, n_crc = 0, n_ovf = 0;
    int          b_magic = 0, b_len = 0, b_crc = 0, b_ovf = 0;
    int          exp_frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Count error pulses since the previous call and compare with expectation.
    task automatic chk_errs(input int m, input int l, input int c, input int o);
        chk("err_magic_count", 32'(n_magic - b_magic), 32'(m));
        chk("err_len_count",   32'(n_len - b_len),     32'(l));
        chk("err_crc_count",   32'(n_crc - b_crc),     32'(c));
        chk("err_ovf_count",   32'(n_ovf - b_ovf),     32'(o));
        b_magic = n_magic; b_len = n_len; b_crc = n_crc; b_ovf = n_ovf;
    endtask

    // Output monitor: counts error pulses, pops the scoreboard on every
    // transfer and checks that a stalled word does not change.
    task automatic monitor();
        logic        stalled = 1'b0;
        logic [31:0] held = 32'd0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (err_magic) n_magic++;
                if (err_len)   n_len++;
                if (err_crc)   n_crc++;
                if (err_ovf)   n_ovf++;
                if (stalled && out_valid) chk("stall_hold", out_data, held);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", out_data, 32'hDEAD_BEEF);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e[31:0]);
                        chk("out_last", 32'(out_last), 32'(e[32]));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = out_data;
            end
        end
    endtask

    task automatic send(input logic [31:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame of n words base, base+1, ...; checksum is header plus payload.
    task automatic send_frame(input logic [7:0] n, input logic [31:0] base, input bit push);
        logic [31:0] hdr;
        logic [31:0] s;
        hdr = {16'h5646, 8'h00, n};
        s   = hdr;
        for (int i = 0; i < int'(n); i++) begin
            s = s + base + 32'(i);
            if (push) sb.push_back({(i == int'(n) - 1), base + 32'(i)});
        end
        send(hdr);
        for (int i = 0; i < int'(n); i++) send(base + 32'(i));
        send(s);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 32'd0; out_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_last",  32'(out_last), 32'd0);
        chk("rst_frames_ok", 32'(frames_ok), 32'd0);
        chk("rst_err",       32'({err_magic, err_len, err_crc, err_ovf}), 32'd0);
        rst = 1'b0;
        idle(1);

        // Good frame and commit latency
        out_ready = 1'b1;
        sb.push_back({1'b0, 32'h0000_0011});
        sb.push_back({1'b1, 32'h0000_0022});
        send(32'h5646_0002); send(32'h0000_0011); send(32'h0000_0022);
        chk("pre_commit_valid", 32'(out_valid), 32'd0);
        send(32'h5646_0035);
        chk("commit_latency", 32'(out_valid), 32'd1);
        drain();
        exp_frames = 1;
        chk("good_frames_ok", 32'(frames_ok), 32'(exp_frames));
        chk_errs(0, 0, 0, 0);

        // Bad checksum, then a good frame
        send(32'h5646_0002); send(32'h0000_0011); send(32'h0000_0022);
        send(32'h5646_0036);
        chk("crc_pulse", 32'(err_crc), 32'd1);
        idle(4);
        chk("crc_no_valid", 32'(out_valid), 32'd0);
        chk("crc_frames_ok", 32'(frames_ok), 32'(exp_frames));
        chk_errs(0, 0, 1, 0);
        send_frame(8'd2, 32'h0000_0300, 1'b1);
        drain();
        exp_frames++;
        chk("after_crc_frames_ok", 32'(frames_ok), 32'(exp_frames));

        // Header errors
        send(32'h1234_0002);
        chk("magic_pulse", 32'(err_magic), 32'd1);
        send(32'h5646_0000);
        chk("len0_pulse", 32'(err_len), 32'd1);
        send(32'h5646_0009);
        chk("len9_pulse", 32'(err_len), 32'd1);
        send(32'h0000_0011);
        chk("after_len9_magic", 32'(err_magic), 32'd1);
        idle(2);
        chk_errs(2, 2, 0, 0);
        send_frame(8'd1, 32'h0000_0400, 1'b1);
        drain();
        exp_frames++;
        chk("hdr_frames_ok", 32'(frames_ok), 32'(exp_frames));

        // Overflow: fill 16 entries with two committed frames, then overflow
        out_ready = 1'b0;
        send_frame(8'd8, 32'h0000_1000, 1'b1);
        send_frame(8'd8, 32'h0000_2000, 1'b1);
        idle(1);
        exp_frames += 2;
        chk("ovf_fill_frames_ok", 32'(frames_ok), 32'(exp_frames));
        chk("ovf_fill_valid", 32'(out_valid), 32'd1);
        send(32'h5646_0002); send(32'h0000_0077);
        chk("ovf_pulse", 32'(err_ovf), 32'd1);
        send(32'h0000_0088); send(32'h5646_0101);
        idle(2);
        chk_errs(0, 0, 0, 1);
        chk("ovf_frames_ok", 32'(frames_ok), 32'(exp_frames));
        drain();

        // Stall with input gaps and toggling out_ready
        out_ready = 1'b0;
        sb.push_back({1'b0, 32'h0000_00A1});
        sb.push_back({1'b0, 32'h0000_00B2});
        sb.push_back({1'b1, 32'h0000_00C3});
        send(32'h5646_0003); idle(2);
        send(32'h0000_00A1); idle(2);
        send(32'h0000_00B2); idle(2);
        send(32'h0000_00C3); idle(2);
        send(32'h5646_0219); idle(1);
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 2 == 1);
            idle(1);
        end
        drain();
        exp_frames++;
        chk("stall_frames_ok", 32'(frames_ok), 32'(exp_frames));
        chk_errs(0, 0, 0, 0);

        // Reset mid-frame with a committed unread frame in the buffer
        out_ready = 1'b0;
        send_frame(8'd1, 32'h0000_AAAA, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        send(32'h5646_0002); send(32'h0000_1234);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",     32'(out_valid), 32'd0);
        chk("mid_rst_data",      out_data, 32'd0);
        chk("mid_rst_last",      32'(out_last), 32'd0);
        chk("mid_rst_frames_ok", 32'(frames_ok), 32'd0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        exp_frames = 0;
        send_frame(8'd2, 32'h0000_5000, 1'b1);
        exp_frames++;
        drain();
        chk("post_rst_frames_ok", 32'(frames_ok), 32'(exp_frames));
        chk_errs(0, 0, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
